// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and FSM states shared by the mul/div unit
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between a requester and the mul/div unit
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    logic             ovf;
    modport master(output start, op, a, b, input busy, done, hi, lo, div_by_zero, ovf);
    modport slave(input start, op, a, b, output busy, done, hi, lo, div_by_zero, ovf);
endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: turns magnitude results into signed hi/lo
module muldiv_signfix #(parameter int WIDTH = 32) (
    input  logic [2*WIDTH-1:0] mag,
    input  logic               is_div,
    input  logic               sq,
    input  logic               sr,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic [2*WIDTH-1:0] p;
    // product negates as one 2W word; quotient and remainder negate independently
    always_comb begin
        p  = sq ? -mag : mag;
        hi = is_div ? (sr ? -mag[2*WIDTH-1:WIDTH] : mag[2*WIDTH-1:WIDTH]) : p[2*WIDTH-1:WIDTH];
        lo = is_div ? (sq ? -mag[WIDTH-1:0] : mag[WIDTH-1:0]) : p[WIDTH-1:0];
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide with HI/LO result registers
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = 32) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    state_e             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, nxt;
    logic [WIDTH-1:0]   bm, am, bmn, fhi, flo;
    logic [WIDTH:0]     opa, opb, sum;
    logic               is_div, sq, sr, dz, ov, sgn, sa, sb;
    // operand magnitudes at accept, and one shared add/sub step on acc = {hi_part, lo_part}
    always_comb begin
        sgn = bus.op == OP_MULT || bus.op == OP_DIV;
        sa  = sgn & bus.a[WIDTH-1];
        sb  = sgn & bus.b[WIDTH-1];
        am  = sa ? -bus.a : bus.a;
        bmn = sb ? -bus.b : bus.b;
        opa = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
        opb = (is_div || acc[0]) ? {1'b0, bm} : '0;
        sum = is_div ? opa - opb : opa + opb;
        nxt = is_div ? (sum[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                     : {sum, acc[WIDTH-1:1]};
    end
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix (.mag(acc), .is_div(is_div), .sq(sq), .sr(sr), .hi(fhi), .lo(flo));
    // control FSM: accept, WIDTH iteration steps, then one cycle to publish the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            bm              <= '0;
            is_div          <= 1'b0;
            sq              <= 1'b0;
            sr              <= 1'b0;
            dz              <= 1'b0;
            ov              <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.ovf         <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.ovf         <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    if (!bus.op[2]) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        acc      <= {{WIDTH{1'b0}}, am};
                        bm       <= bmn;
                        is_div   <= bus.op[1];
                        sq       <= sa ^ sb;
                        sr       <= sa;
                        dz       <= bus.op[1] && bus.b == '0;
                        ov       <= bus.op == OP_DIV && bus.a == MIN && bus.b == '1;
                    end else if (bus.op == OP_MTHI) bus.hi <= bus.a;
                    else if (bus.op == OP_MTLO) bus.lo <= bus.a;
                end
                RUN: begin
                    acc <= nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    state           <= IDLE;
                    bus.busy        <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.hi          <= fhi;
                    bus.lo          <= dz ? '1 : flo;
                    bus.div_by_zero <= dz;
                    bus.ovf         <= ov;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal range 4..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request strobe; sampled when idle.
REQ-005 SHALL have port op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 SHALL have port a  input  WIDTH  operand A (multiplicand/dividend/MT data).
REQ-007 SHALL have port b  input  WIDTH  operand B (multiplier/divisor).
REQ-008 SHALL have port busy  output  1  high while an arithmetic operation is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse on the cycle HI/LO show a new arithmetic result.
REQ-010 SHALL have port hi  output  WIDTH  registered HI.
REQ-011 SHALL have port lo  output  WIDTH  registered LO.
REQ-012 SHALL have port div_by_zero  output  1  pulses with done when the completed DIV/DIVU had b==0.
REQ-013 SHALL have port ovf  output  1  pulses with done when the completed DIV had a==most-negative and b==all-ones.

Function
REQ-014 States: IDLE, RUN, FIX; busy=1 in RUN and FIX only.
REQ-015 IDLE, start=1, op in MULT..DIVU: latch |a|, |b| (two's-complement magnitude for signed ops, raw for unsigned), result signs, op; clear counter; go to RUN.
REQ-016 RUN: one radix-2 step per cycle (shift-add multiply or restoring divide), exactly WIDTH cycles; counter width clog2(WIDTH); on final step go to FIX.
REQ-017 FIX: apply sign correction; write hi/lo; pulse done (and flags); return to IDLE.
REQ-018 Latency: start accepted at edge E0, hi/lo/done valid after edge E(WIDTH+1); busy high after E0 through E(WIDTH+1) exclusive; back-to-back start accepted on the done cycle.
REQ-019 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product; MULT product negated when operand signs differ.
REQ-020 DIV/DIVU: lo=quotient, hi=remainder; DIV quotient truncates toward zero, remainder takes sign of a.
REQ-021 b==0 (DIV or DIVU): lo=all ones, hi=a unmodified, div_by_zero=1; latency unchanged.
REQ-022 DIV most-negative / -1: lo=most-negative, hi=0, ovf=1.
REQ-023 MTHI/MTLO with start=1 in IDLE: hi (resp. lo) := a at that edge; no busy, no done; other register unchanged.
REQ-024 start while busy (any op) SHALL be ignored; in-flight operation and hi/lo unaffected.
REQ-025 hi/lo SHALL hold their value between operations; intermediate RUN values never visible on hi/lo.
REQ-026 Inputs a, b, op SHALL be sampled only at the accept edge; later changes have no effect.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, div_by_zero=0, ovf=0, hi=0, lo=0, counter=0, regardless of clk.
REQ-028 Reset asserted mid-RUN/FIX SHALL abort the operation; no done pulse follows after release.
REQ-029 First start SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-030 Shared package muldiv_pkg SHALL hold op encodings and the state enum (IDLE, RUN, FIX).
REQ-031 Sign handling SHALL be one combinational sub-module muldiv_signfix (magnitude-in, signs-in, corrected hi/lo out), instantiated once.
REQ-032 Datapath SHALL reuse one 2*WIDTH-bit shift register and one WIDTH+1-bit adder/subtractor for both multiply and divide.

Verification (WIDTH=32)
REQ-033 MULTU a=FFFFFFFF b=FFFFFFFF -> after 33 cycles hi=FFFFFFFE lo=00000001, done high exactly one cycle.
REQ-034 MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1; DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF.
REQ-035 DIVU a=00000007 b=0 -> lo=FFFFFFFF hi=00000007 div_by_zero=1 with done, after 33 cycles.
REQ-036 DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000 ovf=1; DIVU same operands -> lo=00000000 hi=80000000 ovf=0.
REQ-037 MULTU 2*3 started, start MTHI a=12345678 at cycle 5 -> ignored, result hi=0 lo=6; then idle MTHI a=12345678 -> hi=12345678 next edge, lo=6, no done.
REQ-038 rst_n low at cycle 10 of DIV -> busy, done, hi, lo zero immediately, no done after release; next MULTU 4*4 -> lo=00000010.
